// File: rtl/pwm_pkg.sv
// pwm_pkg
// Shared definitions for the PWM blocks (pwm_gen, pwm_meas) and their benches.
//   PWM_CNT_W    : default width of PWM period/duty/measurement counters
//   meas_state_t : pwm_meas controller states (IDLE, ARM, MEAS)
package pwm_pkg;

    localparam int PWM_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } meas_state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// pwm_sync_edge
// Brings an asynchronous level into the clk domain and flags its rising edges.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, clears all flops
//   d    : asynchronous input level
//   q    : synchronised level, time-aligned with rise
//   rise : one-cycle pulse, synchronised level went 0 -> 1
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic                   rise_reg;

    // rise is registered so the edge decision is a clean flop output; prev_reg
    // is exported as q because it is the level that belongs to the same cycle
    // as rise_reg (the first high sample coincides with the rise pulse).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
            rise_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
            prev_reg <= sync_reg[SYNC_STAGES-1];
            rise_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
        end
    end

    assign q    = prev_reg;
    assign rise = rise_reg;

endmodule

// File: rtl/pwm_meas.sv
// pwm_meas
// Measures period (rising edge to rising edge) and high time of a PWM input,
// in clk cycles.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   pwm_in     : PWM waveform, may be asynchronous to clk
//   meas_en    : level enable; low forces IDLE and clears the counters
//   period_out : last measured period (saturates at 2^CNT_W-1)
//   high_out   : last measured high time within that period
//   meas_valid : one-cycle pulse, new period_out/high_out
//   ovf        : published period saturated (read with meas_valid)
//   stalled    : period counter is pinned at saturation while measuring
module pwm_meas
    import pwm_pkg::*;
#(
    parameter int CNT_W       = PWM_CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    input  logic             meas_en,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             ovf,
    output logic             stalled
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    meas_state_t      state_reg, state_next;
    logic [CNT_W-1:0] period_cnt_reg, period_cnt_next;
    logic [CNT_W-1:0] high_cnt_reg, high_cnt_next;
    logic [CNT_W-1:0] period_out_reg, period_out_next;
    logic [CNT_W-1:0] high_out_reg, high_out_next;
    logic             valid_reg, valid_next;
    logic             ovf_reg, ovf_next;

    logic             pwm_q;
    logic             pwm_rise;

    pwm_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (pwm_in),
        .q    (pwm_q),
        .rise (pwm_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            period_cnt_reg <= '0;
            high_cnt_reg   <= '0;
            period_out_reg <= '0;
            high_out_reg   <= '0;
            valid_reg      <= 1'b0;
            ovf_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            period_cnt_reg <= period_cnt_next;
            high_cnt_reg   <= high_cnt_next;
            period_out_reg <= period_out_next;
            high_out_reg   <= high_out_next;
            valid_reg      <= valid_next;
            ovf_reg        <= ovf_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        period_cnt_next = period_cnt_reg;
        high_cnt_next   = high_cnt_reg;
        period_out_next = period_out_reg;
        high_out_next   = high_out_reg;
        valid_next      = 1'b0;
        ovf_next        = ovf_reg;

        if (!meas_en) begin
            // Disable wins over everything, including an edge in this cycle;
            // published results are left untouched.
            state_next      = ST_IDLE;
            period_cnt_next = '0;
            high_cnt_next   = '0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    state_next = ST_ARM;
                end
                ST_ARM: begin
                    // First edge only opens a period; nothing to publish yet.
                    if (pwm_rise) begin
                        state_next      = ST_MEAS;
                        period_cnt_next = CNT_ONE;
                        high_cnt_next   = CNT_ONE;
                    end
                end
                ST_MEAS: begin
                    if (pwm_rise) begin
                        period_out_next = period_cnt_reg;
                        high_out_next   = high_cnt_reg;
                        ovf_next        = (period_cnt_reg == CNT_MAX);
                        valid_next      = 1'b1;
                        // The edge cycle is the first cycle of the new period
                        // and is already high, hence reload to 1 rather than 0.
                        period_cnt_next = CNT_ONE;
                        high_cnt_next   = CNT_ONE;
                    end else begin
                        if (period_cnt_reg != CNT_MAX) begin
                            period_cnt_next = period_cnt_reg + CNT_ONE;
                        end
                        if (pwm_q && (high_cnt_reg != CNT_MAX)) begin
                            high_cnt_next = high_cnt_reg + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign period_out = period_out_reg;
    assign high_out   = high_out_reg;
    assign meas_valid = valid_reg;
    assign ovf        = ovf_reg;
    assign stalled    = (state_reg == ST_MEAS) && (period_cnt_reg == CNT_MAX);

endmodule

// File: tb/tb_pwm_meas.sv
// tb_pwm_meas
// Directed bench for pwm_meas: one instance with SYNC_STAGES=2 carries the
// functional checks, a second with SYNC_STAGES=3 shares the stimulus and is
// used for the latency comparison.
module tb_pwm_meas;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             pwm_in;
    logic             meas_en;
    logic [CNT_W-1:0] period_out, high_out, period_out3, high_out3;
    logic             meas_valid, ovf, stalled;
    logic             meas_valid3, ovf3, stalled3;

    always #5 clk = ~clk;

    pwm_meas #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .meas_en    (meas_en),
        .period_out (period_out),
        .high_out   (high_out),
        .meas_valid (meas_valid),
        .ovf        (ovf),
        .stalled    (stalled)
    );

    pwm_meas #(.CNT_W(CNT_W), .SYNC_STAGES(3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .meas_en    (meas_en),
        .period_out (period_out3),
        .high_out   (high_out3),
        .meas_valid (meas_valid3),
        .ovf        (ovf3),
        .stalled    (stalled3)
    );

    int   n_chk = 0;
    int   n_err = 0;

    // Stimulus generator state: gen_period == 0 means a constant gen_level.
    int   gen_period = 0;
    int   gen_high   = 0;
    int   phase      = 0;
    logic gen_level  = 1'b0;

    int   step_no         = 0;
    int   n_valid         = 0;
    int   n_valid3        = 0;
    int   last_valid_step = -1;
    bit   chk_vals        = 1'b0;
    bit   chk_gap         = 1'b0;
    int   exp_period      = 0;
    int   exp_high        = 0;
    int   exp_ovf         = 0;
    int   stall_first     = -1;
    int   stall_cnt       = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clk cycle: drive pwm_in for the coming edge, then observe #1 later.
    task automatic step();
        int cur;
        if (gen_period == 0) begin
            pwm_in = gen_level;
        end else begin
            pwm_in = (phase < gen_high);
            phase  = (phase + 1 >= gen_period) ? 0 : phase + 1;
        end
        @(posedge clk);
        #1;
        cur = step_no;
        step_no++;
        if (stalled) begin
            if (stall_first < 0) stall_first = cur;
            stall_cnt++;
        end
        if (meas_valid3) n_valid3++;
        if (meas_valid) begin
            n_valid++;
            $display("step %0d: meas_valid period=%0d high=%0d ovf=%0d",
                     cur, period_out, high_out, ovf);
            if (chk_vals) begin
                chk("valid_period", int'(period_out), exp_period);
                chk("valid_high", int'(high_out), exp_high);
                chk("valid_ovf", int'(ovf), exp_ovf);
            end
            if (chk_gap && last_valid_step >= 0)
                chk("valid_gap", cur - last_valid_step, gen_period);
            last_valid_step = cur;
        end
    endtask

    task automatic run_to_phase(input int p);
        for (int i = 0; i < 1000 && phase != p; i++) step();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        meas_en    = 1'b0;
        gen_period = 0;
        gen_level  = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nv, nv3, k2, k3;
        rst     = 1'b1;
        meas_en = 1'b0;
        pwm_in  = 1'b0;

        // Reset state
        do_reset();
        chk("rst_period", int'(period_out), 0);
        chk("rst_high", int'(high_out), 0);
        chk("rst_valid", int'(meas_valid), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_stalled", int'(stalled), 0);

        // Steady 200/15: edges at steps 0,200,..,800; first is discarded
        gen_period = 200; gen_high = 15; phase = 0; meas_en = 1'b1;
        exp_period = 200; exp_high = 15; exp_ovf = 0;
        chk_vals = 1'b1; chk_gap = 1'b1; last_valid_step = -1; n_valid = 0;
        repeat (1000) step();
        chk("n_valid_200", n_valid, 4);
        chk("stalled_200", int'(stalled), 0);

        // Enable dropped mid-period, then re-armed: next edge is discarded
        chk_gap = 1'b0;
        run_to_phase(100);
        nv = n_valid;
        meas_en = 1'b0;
        repeat (20) step();
        meas_en = 1'b1;
        run_to_phase(10);
        chk("drop_mid_novalid", n_valid - nv, 0);
        chk("drop_mid_period", int'(period_out), 200);
        chk("drop_mid_high", int'(high_out), 15);
        chk("drop_mid_ovf", int'(ovf), 0);

        // Enable low exactly in the edge cycle (3 edges after sampling)
        run_to_phase(0);
        repeat (3) step();
        meas_en = 1'b0;
        step();
        meas_en = 1'b1;
        chk("drop_edge_novalid", n_valid - nv, 0);
        chk("drop_edge_period", int'(period_out), 200);
        chk("drop_edge_high", int'(high_out), 15);
        repeat (390) step();
        chk("reen_first_edge", n_valid - nv, 0);
        repeat (15) step();
        chk("reen_second_edge", n_valid - nv, 1);

        // 300/100 saturates: stalled from step 257 through 302, valid at 303
        do_reset();
        step_no = 0; stall_first = -1; stall_cnt = 0; nv = n_valid;
        gen_period = 300; gen_high = 100; phase = 0; meas_en = 1'b1;
        exp_period = 255; exp_high = 100; exp_ovf = 1;
        repeat (303) step();
        chk("stall_first", stall_first, 257);
        chk("stall_cnt", stall_cnt, 46);
        chk("sat_novalid_yet", n_valid - nv, 0);
        step();
        chk("sat_valid", n_valid - nv, 1);
        chk("stall_clear", int'(stalled), 0);

        // Input held low: stays ARM, no valid, never stalled
        do_reset();
        nv = n_valid; stall_cnt = 0;
        meas_en = 1'b1; gen_period = 0; gen_level = 1'b0;
        repeat (1000) step();
        chk("hold0_novalid", n_valid - nv, 0);
        chk("hold0_stall_cnt", stall_cnt, 0);
        gen_period = 10; gen_high = 3; phase = 0;
        exp_period = 10; exp_high = 3; exp_ovf = 0;
        repeat (13) step();
        chk("p10_first_edge", n_valid - nv, 0);
        step();
        chk("p10_second_edge", n_valid - nv, 1);

        // Reset mid-measurement with meas_en still high
        run_to_phase(5);
        nv = n_valid;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_period", int'(period_out), 0);
        chk("mrst_high", int'(high_out), 0);
        chk("mrst_valid", int'(meas_valid), 0);
        chk("mrst_ovf", int'(ovf), 0);
        chk("mrst_stalled", int'(stalled), 0);
        repeat (17) step();
        chk("mrst_first_edge", n_valid - nv, 0);
        step();
        chk("mrst_second_edge", n_valid - nv, 1);

        // Latency: valid 3 (S=2) and 4 (S=3) edges after the sampling edge
        chk_vals = 1'b0;
        do_reset();
        meas_en = 1'b1; gen_period = 0; gen_level = 1'b0;
        repeat (4) step();
        gen_level = 1'b1;
        repeat (4) step();
        gen_level = 1'b0;
        repeat (8) step();
        nv = n_valid; nv3 = n_valid3; k2 = 0; k3 = 0;
        gen_level = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (meas_valid && k2 == 0) k2 = k;
            if (meas_valid3 && k3 == 0) k3 = k;
        end
        chk("latency_s2", k2 - 1, 3);
        chk("latency_s3", k3 - 1, 4);
        chk("pulse_s2", n_valid - nv, 1);
        chk("pulse_s3", n_valid3 - nv3, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pwm_meas.md
PWM_MEAS -- requirements
Module: pwm_meas

Interface
REQ-001 SHALL have parameter CNT_W, default 8, giving the width of the measurement counters and outputs (matches pwm_gen period/duty width).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the number of synchroniser flops on pwm_in (legal range 2..3).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port pwm_in, input, 1, the PWM waveform under measurement (e.g. pwm_gen pwm_out); may be asynchronous to clk.
REQ-006 SHALL have port meas_en, input, 1, measurement enable; level-sensitive.
REQ-007 SHALL have port period_out, output, CNT_W, the last measured period in clk cycles (rising edge to rising edge).
REQ-008 SHALL have port high_out, output, CNT_W, the last measured high time in clk cycles within that period.
REQ-009 SHALL have port meas_valid, output, 1, a one-cycle pulse marking new period_out/high_out.
REQ-010 SHALL have port ovf, output, 1, qualified by meas_valid: the published period saturated.
REQ-011 SHALL have port stalled, output, 1, a level that is high while the period counter is held at saturation (no rising edge seen).

Function
REQ-012 SHALL pass pwm_in through SYNC_STAGES flops, then detect rising edges as synced high with the previous synced value low.
REQ-013 SHALL implement states IDLE, ARM and MEAS.
- IDLE→ARM when meas_en=1.
- ARM→MEAS on the first rising edge.
- Any state→IDLE when meas_en=0.
REQ-014 SHALL, on the ARM→MEAS edge cycle, load period_cnt=1 and high_cnt=1, with no meas_valid.
REQ-015 SHALL, in MEAS on non-edge cycles, increment period_cnt, and increment high_cnt if synced pwm_in=1; both counters saturate at 2^CNT_W-1 and never wrap.
REQ-016 SHALL, in MEAS on an edge cycle:
- register period_out=period_cnt, high_out=high_cnt, and ovf=(period_cnt saturated);
- reload both counters to 1;
- pulse meas_valid for exactly one cycle, visible in the cycle after the edge.
REQ-017 SHALL assert meas_valid SYNC_STAGES+1 clk edges after the first clk edge that samples pwm_in high.
REQ-018 SHALL hold period_out, high_out and ovf stable between meas_valid pulses, including through IDLE.
REQ-019 SHALL drive stalled=1 in MEAS while period_cnt is saturated, and clear it on the next rising edge or on leaving MEAS.
REQ-020 SHALL give meas_en=0 priority when it coincides with an edge: no meas_valid, go to IDLE, clear counters.
REQ-021 SHALL, on re-enable, discard the first edge (ARM), so the first meas_valid follows the second edge.
REQ-022 SHALL produce no meas_valid for 0 % or 100 % duty input (no rising edges); stalled rises after 2^CNT_W-2 cycles in MEAS.

Reset
REQ-023 SHALL, with rst=1 at a clk edge, set state=IDLE and clear synchroniser flops, counters, period_out, high_out, meas_valid, ovf and stalled to 0.
REQ-024 SHALL let rst override meas_en and any in-progress measurement; no meas_valid is issued from a partial period.

Structure
REQ-025 SHALL place the state encoding (IDLE/ARM/MEAS) and the default CNT_W constant in shared package pwm_pkg, also used by pwm_gen benches.
REQ-026 SHALL implement the synchroniser plus rising-edge detector as sub-module pwm_sync_edge (params SYNC_STAGES; ports clk, rst, d, q, rise).

Verification
REQ-027 SHALL verify: pwm_gen period=200, duty_cycle=15 driving pwm_in, meas_en=1 → after the first (discarded) edge, every meas_valid shows period_out=200, high_out=15, ovf=0, with pulses spaced 200 cycles.
REQ-028 SHALL verify: pwm_in period 300, high 100 → meas_valid with period_out=255, high_out=100, ovf=1; stalled high from 254 cycles after the edge until the next edge.
REQ-029 SHALL verify: pwm_in held 0 for 1000 cycles with meas_en=1 → no meas_valid, stalled=0 (stays ARM); then period 10, high 3 → first meas_valid after the 2nd edge with 10/3.
REQ-030 SHALL verify: meas_en dropped mid-period, and dropped in the exact edge cycle → no meas_valid, outputs keep the prior 200/15; re-enable → first new valid after two edges.
REQ-031 SHALL verify: rst pulsed mid-measurement → all outputs 0 on the next cycle; no valid until two edges after rst release.
REQ-032 SHALL verify: latency with SYNC_STAGES=2 and 3 → meas_valid exactly 3 and 4 clk edges respectively after the sampling edge.
